// File: rtl/fft64_stage_controller.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed load, LOG2N butterfly
// stages separated by a write-back drain, then a natural-order handshaked unload.
module fft64_stage_controller #(
    parameter int LOG2N    = 6,
    parameter int PIPE_LAT = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_load_we,
    output logic [LOG2N-1:0] o_load_addr,
    output logic             o_bf_rd_en,
    output logic [LOG2N-1:0] o_bf_addr_a,
    output logic [LOG2N-1:0] o_bf_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic [2:0]       o_stage,
    output logic             o_bf_we,
    output logic [LOG2N-1:0] o_bf_wr_addr_a,
    output logic [LOG2N-1:0] o_bf_wr_addr_b,
    output logic             o_out_rd_en,
    output logic [LOG2N-1:0] o_out_addr,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_hold,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;

    state_t r_state, w_state_nxt;

    logic [LOG2N-1:0] r_ld_cnt;
    logic [LOG2N-2:0] r_b;
    logic [2:0]       r_stage;
    logic [2:0]       r_drain;
    logic [LOG2N:0]   r_rd_idx;
    logic [LOG2N-1:0] r_hs_cnt;
    logic [LOG2N-1:0] r_out_addr;
    logic             r_out_valid;
    logic             r_done;

    logic [PIPE_LAT-1:0]            r_we_dly;
    logic [PIPE_LAT-1:0][LOG2N-1:0] r_wa_dly;
    logic [PIPE_LAT-1:0][LOG2N-1:0] r_wb_dly;

    logic             w_load_we, w_ld_last, w_b_last, w_drain_last, w_last_stage;
    logic             w_rd, w_out_rd, w_hs, w_hs_last;
    logic [LOG2N-1:0] w_bitrev, w_b_ext, w_lo_mask, w_addr_a, w_addr_b;
    logic [LOG2N-2:0] w_tw;

    assign w_load_we    = (r_state == S_LOAD) && i_in_valid;
    assign w_ld_last    = w_load_we && (&r_ld_cnt);
    assign w_b_last     = &r_b;
    assign w_drain_last = (r_drain == 3'(PIPE_LAT - 1));
    assign w_last_stage = (r_stage == 3'(LOG2N - 1));
    assign w_rd         = (r_state == S_COMPUTE);
    // A new read is issued only when the output register is empty or draining this cycle.
    assign w_out_rd     = (r_state == S_UNLOAD) && !r_rd_idx[LOG2N] && (!r_out_valid || i_out_ready);
    assign w_hs         = (r_state == S_UNLOAD) && r_out_valid && i_out_ready;
    assign w_hs_last    = w_hs && (&r_hs_cnt);

    always_comb begin
        w_bitrev = '0;
        for (int i = 0; i < LOG2N; i++) w_bitrev[i] = r_ld_cnt[LOG2N-1-i];
    end

    // Butterfly pair: insert a 0 bit at position stage into b; partner sets that bit.
    assign w_b_ext   = {1'b0, r_b};
    assign w_lo_mask = (LOG2N'(1) << r_stage) - LOG2N'(1);
    assign w_addr_a  = ((w_b_ext >> r_stage) << (r_stage + 3'd1)) | (w_b_ext & w_lo_mask);
    assign w_addr_b  = w_addr_a | (LOG2N'(1) << r_stage);
    assign w_tw      = (r_b & w_lo_mask[LOG2N-2:0]) << (3'(LOG2N - 1) - r_stage);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start)      w_state_nxt = S_LOAD;
            S_LOAD:    if (w_ld_last)    w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_b_last)     w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_last) w_state_nxt = w_last_stage ? S_UNLOAD : S_COMPUTE;
            S_UNLOAD:  if (w_hs_last)    w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld_cnt    <= '0;
            r_b         <= '0;
            r_stage     <= '0;
            r_drain     <= '0;
            r_rd_idx    <= '0;
            r_hs_cnt    <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_hs_last;
            case (r_state)
                S_IDLE: r_ld_cnt <= '0;
                S_LOAD: begin
                    if (w_load_we) r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + 1'b1;
                    if (w_ld_last) begin
                        r_stage <= '0;
                        r_b     <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_b     <= w_b_last ? '0 : r_b + 1'b1;
                    r_drain <= '0;
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (w_drain_last) begin
                        if (w_last_stage) begin
                            r_rd_idx    <= '0;
                            r_hs_cnt    <= '0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_b     <= '0;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (w_out_rd) begin
                        r_rd_idx    <= r_rd_idx + 1'b1;
                        r_out_addr  <= r_rd_idx[LOG2N-1:0];
                        r_out_valid <= 1'b1;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_hs) r_hs_cnt <= w_hs_last ? '0 : r_hs_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write-back delay line runs every cycle so the last write lands in the final drain cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we_dly <= '0;
            r_wa_dly <= '0;
            r_wb_dly <= '0;
        end else begin
            r_we_dly[0] <= w_rd;
            r_wa_dly[0] <= w_rd ? w_addr_a : '0;
            r_wb_dly[0] <= w_rd ? w_addr_b : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_we_dly[i] <= r_we_dly[i-1];
                r_wa_dly[i] <= r_wa_dly[i-1];
                r_wb_dly[i] <= r_wb_dly[i-1];
            end
        end
    end

    assign o_in_ready     = (r_state == S_LOAD);
    assign o_load_we      = w_load_we;
    assign o_load_addr    = w_load_we ? w_bitrev : '0;
    assign o_bf_rd_en     = w_rd;
    assign o_bf_addr_a    = w_rd ? w_addr_a : '0;
    assign o_bf_addr_b    = w_rd ? w_addr_b : '0;
    assign o_tw_addr      = w_rd ? w_tw : '0;
    assign o_stage        = r_stage;
    assign o_bf_we        = r_we_dly[PIPE_LAT-1];
    assign o_bf_wr_addr_a = r_wa_dly[PIPE_LAT-1];
    assign o_bf_wr_addr_b = r_wb_dly[PIPE_LAT-1];
    assign o_out_rd_en    = w_out_rd;
    assign o_out_addr     = w_out_rd ? r_rd_idx[LOG2N-1:0] : r_out_addr;
    assign o_out_valid    = r_out_valid;
    assign o_out_hold     = r_out_valid && !i_out_ready;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
endmodule

// File: tb/tb_fft64_stage_controller.sv
// Bench for fft64_stage_controller: phase-level reference model checked every cycle
// against the DUT, with directed load/hold/reset scenarios and a randomized transform.
module tb_fft64_stage_controller;
    localparam int PL   = 3;
    localparam int SPAN = 32 + PL;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, load_we, bf_rd_en, bf_we, out_rd_en, out_valid, out_hold, busy, done;
    logic [5:0] load_addr, bf_addr_a, bf_addr_b, bf_wr_addr_a, bf_wr_addr_b, out_addr;
    logic [4:0] tw_addr;
    logic [2:0] stage;

    int checks = 0, errors = 0;

    // Model: phase 0 idle, 1 load, 2 compute (incl. drains), 3 unload.
    int mphase = 0, lcnt = 0, mk = 0, issued = 0, hs = 0, mheld = 0, mdone_total = 0;
    bit mvalid = 0, mdone = 0;
    int hist_rd[PL], hist_a[PL], hist_b[PL];
    int dut_held = 0, ldc = 0, ldwe = 0, rdc = 0, holdc = 0, done_cnt = 0;
    bit toggle_test = 0, hold_test = 0;
    int lit_ld[5] = '{0, 32, 16, 48, 8};
    int st, j;
    bit erd, eord, hsn;

    fft64_stage_controller #(.LOG2N(6), .PIPE_LAT(PL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_load_we(load_we), .o_load_addr(load_addr),
        .o_bf_rd_en(bf_rd_en), .o_bf_addr_a(bf_addr_a), .o_bf_addr_b(bf_addr_b),
        .o_tw_addr(tw_addr), .o_stage(stage), .o_bf_we(bf_we),
        .o_bf_wr_addr_a(bf_wr_addr_a), .o_bf_wr_addr_b(bf_wr_addr_b),
        .o_out_rd_en(out_rd_en), .o_out_addr(out_addr), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_hold(out_hold), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bitrev6(input int v);
        int r = 0;
        for (int i = 0; i < 6; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    function automatic int ins0(input int b, input int s);
        return (b / (1 << s)) * (1 << (s + 1)) + (b % (1 << s));
    endfunction

    function automatic int twf(input int b, input int s);
        return (b % (1 << s)) * (1 << (5 - s));
    endfunction

    task automatic model_reset();
        mphase = 0; lcnt = 0; mk = 0; issued = 0; hs = 0; mheld = 0;
        mvalid = 0; mdone = 0; dut_held = 0;
        for (int i = 0; i < PL; i++) begin hist_rd[i] = 0; hist_a[i] = 0; hist_b[i] = 0; end
    endtask

    // Compare process: outputs are sampled on the falling edge, then the model advances.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_load_we", load_we, 0);
                chk("rst_bf_rd_en", bf_rd_en, 0);
                chk("rst_bf_addr_a", bf_addr_a, 0);
                chk("rst_tw_addr", tw_addr, 0);
                chk("rst_stage", stage, 0);
                chk("rst_bf_we", bf_we, 0);
                chk("rst_out_rd_en", out_rd_en, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_hold", out_hold, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                model_reset();
            end else begin
                st   = mk / SPAN;
                j    = mk % SPAN;
                erd  = (mphase == 2) && (j < 32);
                eord = (mphase == 3) && (issued < 64) && (!mvalid || out_ready);
                hsn  = mvalid && out_ready;

                chk("busy", busy, int'(mphase != 0));
                chk("done", done, mdone);
                chk("in_ready", in_ready, int'(mphase == 1));
                chk("load_we", load_we, int'(mphase == 1 && in_valid));
                if (mphase == 1 && in_valid) begin
                    chk("load_addr", load_addr, bitrev6(lcnt));
                    if (lcnt < 5) chk("lit_load_addr", load_addr, lit_ld[lcnt]);
                end

                chk("bf_rd_en", bf_rd_en, erd);
                if (mphase == 2) chk("stage", stage, st);
                if (erd) begin
                    chk("bf_addr_a", bf_addr_a, ins0(j, st));
                    chk("bf_addr_b", bf_addr_b, ins0(j, st) + (1 << st));
                    chk("tw_addr", tw_addr, twf(j, st));
                end
                if (mphase == 2 && mk == 3) begin
                    chk("lit_s0b3_a", bf_addr_a, 6);
                    chk("lit_s0b3_b", bf_addr_b, 7);
                    chk("lit_s0b3_tw", tw_addr, 0);
                end
                if (mphase == 2 && mk == 2 * SPAN + 5) begin
                    chk("lit_s2b5_a", bf_addr_a, 9);
                    chk("lit_s2b5_b", bf_addr_b, 13);
                    chk("lit_s2b5_tw", tw_addr, 8);
                end
                if (mphase == 2 && mk == 5 * SPAN + 3) begin
                    chk("lit_s5b3_a", bf_addr_a, 3);
                    chk("lit_s5b3_b", bf_addr_b, 35);
                    chk("lit_s5b3_tw", tw_addr, 3);
                end

                chk("bf_we", bf_we, hist_rd[PL-1]);
                if (hist_rd[PL-1] != 0) begin
                    chk("bf_wr_addr_a", bf_wr_addr_a, hist_a[PL-1]);
                    chk("bf_wr_addr_b", bf_wr_addr_b, hist_b[PL-1]);
                end

                chk("out_valid", out_valid, mvalid);
                chk("out_hold", out_hold, int'(mvalid && !out_ready));
                chk("out_rd_en", out_rd_en, eord);
                if (eord) chk("out_addr", out_addr, issued);
                else if (mvalid && !out_ready) chk("out_addr_frozen", out_addr, mheld);
                if (out_valid && out_ready && mphase == 3) chk("hs_order", dut_held, hs);
                if (out_rd_en) dut_held = out_addr;

                if (in_ready) ldc++;
                if (load_we) ldwe++;
                if (bf_rd_en) rdc++;
                if (out_hold) holdc++;
                if (done) done_cnt++;

                for (int i = PL - 1; i > 0; i--) begin
                    hist_rd[i] = hist_rd[i-1]; hist_a[i] = hist_a[i-1]; hist_b[i] = hist_b[i-1];
                end
                hist_rd[0] = erd;
                hist_a[0]  = erd ? ins0(j, st) : 0;
                hist_b[0]  = erd ? ins0(j, st) + (1 << st) : 0;

                mdone = 0;
                case (mphase)
                    0: if (start) begin mphase = 1; lcnt = 0; ldc = 0; ldwe = 0; end
                    1: if (in_valid) begin
                        lcnt++;
                        if (lcnt == 64) begin
                            mphase = 2; mk = 0; rdc = 0;
                            if (toggle_test) begin
                                chk("load_cycles", ldc, 128);
                                chk("load_writes", ldwe, 64);
                            end
                        end
                    end
                    2: begin
                        mk++;
                        if (mk == 6 * SPAN) begin
                            mphase = 3; issued = 0; hs = 0; mvalid = 0; holdc = 0;
                            chk("rd_en_count", rdc, 192);
                        end
                    end
                    3: begin
                        if (hsn) hs++;
                        if (eord) begin mheld = issued; issued++; mvalid = 1; end
                        else if (hsn) mvalid = 0;
                        if (hs == 64) begin
                            mphase = 0; mdone = 1; mvalid = 0; mdone_total++;
                            if (hold_test) chk("hold_cycles", holdc, 5);
                        end
                    end
                    default: mphase = 0;
                endcase
            end
        end
    end

    task automatic wait_phase(input int ph, input int budget, input string nm);
        int n = 0;
        while (mphase != ph && n < budget) begin @(posedge clk); #1; n++; end
        checks++;
        if (mphase != ph) begin
            errors++;
            $display("FAIL timeout_%s: phase %0d expected %0d", nm, mphase, ph);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Contiguous load, then abort with reset at stage 2, b = 10.
        @(posedge clk); #1;
        pulse_start();
        in_valid = 1'b1;
        repeat (64) @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!(mphase == 2 && mk == 2 * SPAN + 10) && n < 400) begin @(posedge clk); #1; n++; end
        chk("reach_stage2_b10", int'(mphase == 2 && mk == 2 * SPAN + 10), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Alternating in_valid load, then a 5-cycle stall while index 20 is held.
        toggle_test = 1'b1;
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            in_valid = (i % 2 == 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        toggle_test = 1'b0;
        hold_test = 1'b1;
        wait_phase(3, 300, "unload_b");
        begin
            int hc = 0;
            n = 0;
            while (mphase == 3 && n < 400) begin
                if (mvalid && mheld == 20 && hc < 5) begin out_ready = 1'b0; hc++; end
                else out_ready = 1'b1;
                @(posedge clk); #1;
                n++;
            end
        end
        chk("unload_b_finished", mphase, 0);
        hold_test = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Randomized transform with start/in_valid noise and random backpressure.
        pulse_start();
        n = 0;
        while (mdone_total < 2 && n < 3000) begin
            in_valid  = 1'($urandom % 2);
            out_ready = ($urandom % 4) != 0;
            start     = (mphase == 2 || mphase == 3) ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("random_transform_done", mdone_total, 2);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("done_pulses", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule

// File: doc/fft64_stage_controller.md
Name: fft64_stage_controller

Overview:
- Sequencer for the in-place radix-2 DIT 64-point FFT datapath: sample RAM, butterfly unit, twiddle ROM, and hold-register output stage.
- Accepts 64 input samples and writes them to RAM in bit-reversed order.
- Issues 6 stages of 32 butterfly read/write address pairs with twiddle indices, then streams 64 results out under a valid/ready handshake.
- Drives the hold enable of the output hold registers during backpressure.

Parameters:
- LOG2N, 6, log2 of FFT size (N=64; butterflies per stage = N/2 = 32).
- PIPE_LAT, 3, cycles from butterfly operand issue to result write-back (RAM read + butterfly pipeline), range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a transform; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts sample (LOAD state).
- load_we  out  1  RAM write enable for input sample (= in_valid & in_ready).
- load_addr  out  LOG2N  bit-reversed load address.
- bf_rd_en  out  1  butterfly operand read enable.
- bf_addr_a  out  LOG2N  upper operand address.
- bf_addr_b  out  LOG2N  lower operand address (addr_a | 1<<stage).
- tw_addr  out  LOG2N-1  twiddle ROM index.
- stage  out  3  current stage 0..5.
- bf_we  out  1  butterfly result write enable (bf_rd_en delayed PIPE_LAT).
- bf_wr_addr_a  out  LOG2N  bf_addr_a delayed PIPE_LAT.
- bf_wr_addr_b  out  LOG2N  bf_addr_b delayed PIPE_LAT.
- out_rd_en  out  1  RAM read enable for unload.
- out_addr  out  LOG2N  natural-order unload address.
- out_valid  out  1  output sample valid at output hold register.
- out_ready  in  1  downstream accepts output.
- out_hold  out  1  hold enable for output hold registers.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (async, immediate): state IDLE; all counters 0; all outputs 0; delay lines cleared. in_ready, bf_we and out_valid are 0 during and after reset. Reset mid-transform aborts without a done pulse.
- States: IDLE -> LOAD -> COMPUTE -> DRAIN -> (COMPUTE | UNLOAD) -> IDLE.
- IDLE: busy=0. start=1 -> LOAD next cycle with load count = 0.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1: load_we=1, load_addr = bitrev6(count), count++.
  - in_valid=0 stalls with no change.
  - After the 64th transfer -> COMPUTE, stage=0, b=0.
- COMPUTE:
  - bf_rd_en=1 every cycle; b counts 0..31.
  - bf_addr_a = ((b>>s)<<(s+1)) | (b & ((1<<s)-1)).
  - bf_addr_b = bf_addr_a | (1<<s).
  - tw_addr = (b & ((1<<s)-1)) << (5-s).
  - After b=31 -> DRAIN.
- DRAIN:
  - bf_rd_en=0 for exactly PIPE_LAT cycles, so the final write of the stage lands before the first read of the next stage (RAW hazard).
  - Then stage<5 -> COMPUTE with stage+1, b=0; stage=5 -> UNLOAD.
  - Total compute span = 6*(32+PIPE_LAT) cycles.
- bf_we/bf_wr_addr_*: shift-register delay of bf_rd_en/bf_addr_* by exactly PIPE_LAT cycles, independent of state. The last write occurs in the final DRAIN cycle.
- UNLOAD:
  - out_rd_en=1 with out_addr = next index when the output register is empty or being consumed (out_valid=0 or out_ready=1).
  - out_valid rises 1 cycle after out_rd_en (1-cycle RAM latency).
  - out_valid=1 & out_ready=0: out_hold=1, out_rd_en=0, out_addr frozen, output register retains data. No sample is lost or duplicated.
  - Handshake = out_valid & out_ready.
  - After the 64th handshake: done=1 for 1 cycle, out_valid=0, -> IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0, load_we=0).
- Counters wrap only via explicit state transition; no modulo wrap mid-phase.

Test Plan:
- Reset mid-COMPUTE (stage 2, b=10), rst=1 one cycle -> outputs 0 same cycle; IDLE; no done; new start runs a full transform correctly.
- start, 64 contiguous in_valid -> load_addr sequence 0,32,16,48,8,...,63; COMPUTE entered the cycle after transfer 64.
- Stage 0 and stage 5 address check -> stage0 b=3: a=6, b=7, tw=0; stage5 b=3: a=3, b=35, tw=3; stage2 b=5: a=9, b=13, tw=8.
- PIPE_LAT=3 -> each stage 32 rd_en then 3 idle cycles; bf_we mirrors rd_en 3 cycles later; last stage-s write precedes first stage-(s+1) read; 210 compute cycles total.
- in_valid toggling 1010... during LOAD -> 128 cycles to fill; load_we only on valid cycles; no address skipped.
- out_ready low for 5 cycles at output index 20 -> out_hold=1 those cycles, out_addr frozen, index 20 delivered exactly once; 64 handshakes in natural order 0..63, then a single done pulse.
